// File: rtl/chacha_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_pkg
//  Description : Shared types and constants for the iterative ChaCha20 block
//                core: word type, step/quarter-round encodings and the
//                column lookup that maps a quarter round onto the matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
package chacha_pkg;

   typedef logic [31:0] word_t;

   // One ARX operation per step.
   // IDLE is the start/park state. S0..S12 are the steps of one quarter round.
   typedef enum logic [3:0] {
      IDLE = 4'd0,
      S0   = 4'd1,
      S1   = 4'd2,
      S2   = 4'd3,
      S3   = 4'd4,
      S4   = 4'd5,
      S5   = 4'd6,
      S6   = 4'd7,
      S7   = 4'd8,
      S8   = 4'd9,
      S9   = 4'd10,
      S10  = 4'd11,
      S11  = 4'd12,
      S12  = 4'd13
   } step_e;

   // Q0..Q3 are column rounds. Q4..Q7 are diagonal rounds.
   typedef enum logic [2:0] {
      Q0 = 3'd0,
      Q1 = 3'd1,
      Q2 = 3'd2,
      Q3 = 3'd3,
      Q4 = 3'd4,
      Q5 = 3'd5,
      Q6 = 3'd6,
      Q7 = 3'd7
   } qround_e;

   localparam logic [3:0] NUM_DOUBLE_ROUNDS = 4'd10;

   // The row is fixed by the operand: row 0 is a, row 1 is b, row 2 is c, row 3 is d.
   // This function returns the column.
   // A column round j uses column j for every row.
   // A diagonal round Q(4+k) uses column (row + k) mod 4.
   function automatic logic [1:0] qcol(input qround_e q, input logic [1:0] row);
      logic [2:0] qv;
      qv = q;
      return qv[2] ? 2'(row + qv[1:0]) : qv[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/chacha_arx_unit.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_arx_unit
//  Description : Combinational single-step ARX datapath. It applies the
//                operation of the step being entered to the a/b/c/d operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module chacha_arx_unit
   import chacha_pkg::*;
(
   input  step_e i_step,
   input  word_t i_a,
   input  word_t i_b,
   input  word_t i_c,
   input  word_t i_d,
   output word_t o_a,
   output word_t o_b,
   output word_t o_c,
   output word_t o_d
);

   // Each step changes at most one operand. The other operands pass through.
   always_comb begin
      o_a = i_a;
      o_b = i_b;
      o_c = i_c;
      o_d = i_d;
      case (i_step)
         S0:      o_a = i_a + i_b;
         S1:      o_d = i_d ^ i_a;
         S2:      o_d = {i_d[15:0], i_d[31:16]};
         S3:      o_c = i_c + i_d;
         S4:      o_b = i_b ^ i_c;
         S5:      o_b = {i_b[19:0], i_b[31:20]};
         S6:      o_a = i_a + i_b;
         S7:      o_d = i_d ^ i_a;
         S8:      o_d = {i_d[23:0], i_d[31:24]};
         S9:      o_c = i_c + i_d;
         S10:     o_b = i_b ^ i_c;
         S11:     o_b = {i_b[24:0], i_b[31:25]};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/perform_qround.sv
`default_nettype none
// ============================================================================
//  Module      : perform_qround
//  Description : Iterative ChaCha20 block core. It runs 10 double rounds
//                through one shared ARX unit at one step per clock. It then
//                adds the captured input to the result (feed-forward).
//  Revision    : 1.0 - initial release
// ============================================================================
module perform_qround
   import chacha_pkg::*;
(
   input  logic                  clk,
   input  logic                  setRounds,
   input  word_t [3:0][3:0]      chachamatrixIN,
   output word_t [3:0][3:0]      chachamatrixOUT,
   output logic                  blockready,
   output logic [3:0]            blocksproduced
);

   // Currstep names the step whose operation the last edge performed.
   // Each edge therefore executes the operation of w_next_step.
   step_e               Currstep;
   step_e               w_next_step;
   qround_e             CurrQ;
   qround_e             w_op_q;
   word_t [3:0][3:0]    r_work;
   word_t [3:0][3:0]    r_in;
   word_t [3:0]         r_op;      // index 0..3 = a..d
   word_t [3:0]         w_src;
   word_t [3:0]         w_arx;
   logic                r_done;

   // Step sequencing. After S12 the FSM starts the next quarter round.
   // It goes to IDLE instead once the last double round has been counted.
   always_comb begin
      w_next_step = Currstep;
      case (Currstep)
         IDLE:    w_next_step = r_done ? IDLE : S0;
         S12:     w_next_step = (CurrQ == Q7 && blocksproduced == NUM_DOUBLE_ROUNDS)
                                ? IDLE : S0;
         default: w_next_step = step_e'(Currstep + 4'd1);
      endcase
   end

   // Select the quarter round that the upcoming S0 belongs to.
   // Select the ARX operands: fresh matrix words on S0, the running registers otherwise.
   always_comb begin
      w_op_q = (Currstep == S12) ? qround_e'(CurrQ + 3'd1) : CurrQ;
      w_src  = r_op;
      if (w_next_step == S0) begin
         for (int r = 0; r < 4; r++) begin
            w_src[r] = r_work[r][qcol(w_op_q, 2'(r))];
         end
      end
   end

   chacha_arx_unit u_arx (
      .i_step (w_next_step),
      .i_a    (w_src[0]),
      .i_b    (w_src[1]),
      .i_c    (w_src[2]),
      .i_d    (w_src[3]),
      .o_a    (w_arx[0]),
      .o_b    (w_arx[1]),
      .o_c    (w_arx[2]),
      .o_d    (w_arx[3])
   );

   // This block holds all the state: load/reset, round progress, write-back and the feed-forward output.
   always_ff @(posedge clk) begin
      if (setRounds) begin
         r_work          <= chachamatrixIN;
         r_in            <= chachamatrixIN;
         r_op            <= '0;
         Currstep        <= IDLE;
         CurrQ           <= Q0;
         chachamatrixOUT <= '0;
         blockready      <= 1'b0;
         blocksproduced  <= 4'd0;
         r_done          <= 1'b0;
      end else begin
         Currstep <= w_next_step;
         r_op     <= w_arx;

         if (Currstep == S12) begin
            CurrQ <= qround_e'(CurrQ + 3'd1);
            if (w_next_step == IDLE) begin
               r_done <= 1'b1;
            end
         end

         // Write-back: the operands already hold the final values of the S11 step.
         if (w_next_step == S12) begin
            for (int r = 0; r < 4; r++) begin
               r_work[r][qcol(CurrQ, 2'(r))] <= r_op[r];
            end
            if (CurrQ == Q7) begin
               blocksproduced <= blocksproduced + 4'd1;
            end
         end

         if (Currstep == IDLE && r_done) begin
            for (int i = 0; i < 4; i++) begin
               for (int j = 0; j < 4; j++) begin
                  chachamatrixOUT[i][j] <= r_work[i][j] + r_in[i][j];
               end
            end
            blockready <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_perform_qround.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perform_qround
//  Description : Self-checking bench for the iterative ChaCha20 block core.
//                A reference model computes each expected block. The bench
//                queues it when the matrix is loaded and pops it when the
//                block is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perform_qround;
   import chacha_pkg::*;

   typedef logic [3:0][3:0][31:0] mat_t;

   logic       clk = 1'b0;
   logic       setRounds;
   mat_t       chachamatrixIN;
   mat_t       chachamatrixOUT;
   logic       blockready;
   logic [3:0] blocksproduced;

   int n_cmp = 0;
   int n_err = 0;
   mat_t exp_q[$];

   perform_qround dut (
      .clk             (clk),
      .setRounds       (setRounds),
      .chachamatrixIN  (chachamatrixIN),
      .chachamatrixOUT (chachamatrixOUT),
      .blockready      (blockready),
      .blocksproduced  (blocksproduced)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // Reference ChaCha20 block on the flat word index i = 4*row + col.
   function automatic mat_t model(input mat_t m);
      logic [31:0] x [16];
      int idx [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                         '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
      mat_t o;
      for (int i = 0; i < 16; i++) x[i] = m[i/4][i%4];
      for (int r = 0; r < 10; r++)
         for (int q = 0; q < 8; q++)
            {x[idx[q][0]], x[idx[q][1]], x[idx[q][2]], x[idx[q][3]]} =
               qr(x[idx[q][0]], x[idx[q][1]], x[idx[q][2]], x[idx[q][3]]);
      for (int i = 0; i < 16; i++) o[i/4][i%4] = x[i] + m[i/4][i%4];
      return o;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = $urandom;
      return m;
   endfunction

   // Hold setRounds for 'cycles' edges. Junk is captured before the final matrix.
   task automatic load(input mat_t m, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         setRounds      = 1'b1;
         chachamatrixIN = (i == cycles - 1) ? m : rand_mat();
         @(posedge clk);
      end
      #1;
      check("rst_step",  64'(dut.Currstep), 64'(0));
      check("rst_q",     64'(dut.CurrQ), 64'(0));
      check("rst_cnt",   64'(blocksproduced), 64'(0));
      check("rst_ready", 64'(blockready), 64'(0));
      check("rst_out0",  64'(chachamatrixOUT == '0), 64'(1));
      check("rst_cap",   64'(dut.r_work == m), 64'(1));
      exp_q.delete();
      exp_q.push_back(model(m));
      @(negedge clk);
      setRounds      = 1'b0;
      chachamatrixIN = rand_mat();
   endtask

   // Sample #1 after each edge e_k (k = 0 is the first edge after release).
   task automatic run(input mat_t m, input bit seq, input bit rfc, input bit zchk,
                      input int stop_at, input int hold);
      mat_t e;
      for (int k = 0; k <= 1041; k++) begin
         @(posedge clk);
         #1;
         if (k == stop_at) return;
         if (seq && k < 1040) begin
            check("step", 64'(dut.Currstep), 64'(1 + k % 13));
            check("qr",   64'(dut.CurrQ), 64'((k / 13) % 8));
            check("cnt",  64'(blocksproduced), 64'((k + 1) / 104));
         end
         if (rfc && k == 12) begin
            check("rfc_a", 64'(dut.r_work[0][0]), 64'(32'hea2a92f4));
            check("rfc_b", 64'(dut.r_work[1][0]), 64'(32'hcb1cf8ce));
            check("rfc_c", 64'(dut.r_work[2][0]), 64'(32'h4581472e));
            check("rfc_d", 64'(dut.r_work[3][0]), 64'(32'h5881c4bb));
            for (int r = 0; r < 4; r++)
               for (int c = 1; c < 4; c++)
                  check("rfc_keep", 64'(dut.r_work[r][c]), 64'(m[r][c]));
         end
         if (zchk && k % 100 == 0)
            check("zero_work", 64'(dut.r_work == '0), 64'(1));
         if (k == 1040) begin
            check("idle_step",  64'(dut.Currstep), 64'(0));
            check("not_ready",  64'(blockready), 64'(0));
         end
         if (k == 1041) begin
            check("ready", 64'(blockready), 64'(1));
            check("final_cnt", 64'(blocksproduced), 64'(10));
            if (exp_q.size() == 0) begin
               check("sb_empty", 64'(1), 64'(0));
               e = '0;
            end else begin
               e = exp_q.pop_front();
            end
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  check($sformatf("out[%0d][%0d]", i, j),
                        64'(chachamatrixOUT[i][j]), 64'(e[i][j]));
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_ready", 64'(blockready), 64'(1));
         check("hold_out",   64'(chachamatrixOUT == e), 64'(1));
         check("hold_cnt",   64'(blocksproduced), 64'(10));
      end
   endtask

   initial begin
      mat_t m;
      setRounds      = 1'b1;
      chachamatrixIN = '0;

      // Reset for 2 cycles, then the RFC quarter-round vector and full sequencing.
      m = rand_mat();
      m[0][0] = 32'h11111111; m[1][0] = 32'h01020304;
      m[2][0] = 32'h9b8d6f43; m[3][0] = 32'h01234567;
      load(m, 2);
      run(m, 1'b1, 1'b1, 1'b0, -1, 3);

      // Random input against the model.
      m = rand_mat();
      load(m, 1);
      run(m, 1'b0, 1'b0, 1'b0, -1, 2);

      // Reset during Q3/S5 with a new matrix, then a full run.
      m = rand_mat();
      load(m, 1);
      run(m, 1'b0, 1'b0, 1'b0, 13 * 3 + 5, 0);
      m = rand_mat();
      load(m, 1);
      run(m, 1'b1, 1'b0, 1'b0, -1, 2);

      // All-zero input. The output must hold for 50 cycles.
      m = '0;
      load(m, 3);
      run(m, 1'b0, 1'b0, 1'b1, -1, 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
